// File: rtl/pc_sequencer16.sv
// Program-counter sequencer: feeds a ripple adder16 with (pc, increment) and
// registers the result as the next fetch address, under a small run-control FSM.

module adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        ci,
  output logic [15:0] sum,
  output logic        co
);

  logic [16:0] carry_s;

  assign carry_s[0] = ci;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign co = carry_s[16];

endmodule

module pc_sequencer16 #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] STEP     = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        load,
  input  logic [15:0] load_addr,
  input  logic        branch,
  input  logic [15:0] br_offset,
  input  logic        pc_ready,
  output logic [15:0] pc_out,
  output logic        pc_valid,
  output logic        wrap,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] pc_r, pc_nxt_s;
  logic        pc_valid_r, wrap_r, wrap_nxt_s;
  logic [15:0] inc_s, sum_s;
  logic        co_s, acc_s;

  // Increment select: a branch offset only when no load overrides it
  always_comb begin
    inc_s = STEP;
    acc_s = pc_valid_r & pc_ready;
    if (branch && !load) begin
      inc_s = br_offset;
    end else begin
      inc_s = STEP;
    end
  end

  adder16 u_adder (
    .a   (pc_r),
    .b   (inc_s),
    .ci  (1'b0),
    .sum (sum_s),
    .co  (co_s)
  );

  // Next-PC priority: load, branch, accepted sequential step, hold
  always_comb begin
    pc_nxt_s   = pc_r;
    wrap_nxt_s = 1'b0;
    if (load) begin
      pc_nxt_s = load_addr;
    end else if (branch) begin
      pc_nxt_s = sum_s;
    end else if (acc_s) begin
      pc_nxt_s   = sum_s;
      wrap_nxt_s = co_s;
    end else begin
      pc_nxt_s   = pc_r;
      wrap_nxt_s = 1'b0;
    end
  end

  // Run-control FSM next state; halt_req outranks start
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (halt_req) state_nxt_s = HALT;
        else          state_nxt_s = RUN;
      end
      HALT: begin
        if (start && !halt_req) state_nxt_s = RUN;
        else                    state_nxt_s = HALT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, PC and flag registers; pc_valid mirrors the RUN state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      pc_valid_r <= 1'b0;
      wrap_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      pc_valid_r <= (state_nxt_s == RUN);
      wrap_r     <= wrap_nxt_s;
    end
  end

  assign pc_out   = pc_r;
  assign pc_valid = pc_valid_r;
  assign wrap     = wrap_r;
  assign state    = state_r;

endmodule

// File: tb/tb_pc_sequencer16.sv
// Directed testbench for pc_sequencer16 with hand-computed expectations.

module tb_pc_sequencer16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        halt_req;
  logic        load;
  logic [15:0] load_addr;
  logic        branch;
  logic [15:0] br_offset;
  logic        pc_ready;
  logic [15:0] pc_out;
  logic        pc_valid;
  logic        wrap;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;

  pc_sequencer16 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .halt_req  (halt_req),
    .load      (load),
    .load_addr (load_addr),
    .branch    (branch),
    .br_offset (br_offset),
    .pc_ready  (pc_ready),
    .pc_out    (pc_out),
    .pc_valid  (pc_valid),
    .wrap      (wrap),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b0; halt_req = 1'b0; load = 1'b0; load_addr = 16'h0000;
    branch = 1'b0; br_offset = 16'h0000; pc_ready = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] addr);
    load = 1'b1; load_addr = addr;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    checks++;
    if ({pc_out, pc_valid, wrap, state} !== {16'h0000, 1'b0, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL reset: pc=%h valid=%b wrap=%b state=%b required pc=0000 valid=0 wrap=0 state=00",
               pc_out, pc_valid, wrap, state);
    end
    rst = 1'b0;
    step();
    checks++;
    if (state !== 2'b00 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: state=%b valid=%b required state=00 valid=0", state, pc_valid);
    end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    start = 1'b1; pc_ready = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 2'b01 || pc_valid !== 1'b1 || pc_out !== 16'h0000) begin
      failures++;
      $display("FAIL start: state=%b valid=%b pc=%h required state=01 valid=1 pc=0000",
               state, pc_valid, pc_out);
    end
    exp_pc = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pc = exp_pc + 16'h0001;
      checks++;
      if (pc_out !== exp_pc || wrap !== 1'b0) begin
        failures++;
        $display("FAIL seq_%0d: pc=%h wrap=%b required pc=%h wrap=0", i, pc_out, wrap, exp_pc);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 2'b01 || pc_out !== 16'h0005) begin
      failures++;
      $display("FAIL start_in_run: state=%b pc=%h required state=01 pc=0005", state, pc_out);
    end
  endtask

  task automatic test_stall();
    pc_ready = 1'b0;
    do_load(16'h0010);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pc_out !== 16'h0010 || pc_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_%0d: pc=%h valid=%b required pc=0010 valid=1", i, pc_out, pc_valid);
      end
    end
  endtask

  task automatic test_wrap();
    pc_ready = 1'b0;
    do_load(16'hFFFF);
    checks++;
    if (pc_out !== 16'hFFFF || wrap !== 1'b0) begin
      failures++;
      $display("FAIL load_ffff: pc=%h wrap=%b required pc=ffff wrap=0", pc_out, wrap);
    end
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    checks++;
    if (pc_out !== 16'h0000 || wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pulse: pc=%h wrap=%b required pc=0000 wrap=1", pc_out, wrap);
    end
    step();
    checks++;
    if (pc_out !== 16'h0000 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_clear: pc=%h wrap=%b required pc=0000 wrap=0", pc_out, wrap);
    end
  endtask

  task automatic test_branch();
    pc_ready = 1'b0;
    do_load(16'h0100);
    branch = 1'b1; br_offset = 16'hFFF0;
    step();
    checks++;
    if (pc_out !== 16'h00F0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL branch_neg: pc=%h wrap=%b required pc=00f0 wrap=0", pc_out, wrap);
    end
    load = 1'b1; load_addr = 16'h1234;
    step();
    load = 1'b0;
    checks++;
    if (pc_out !== 16'h1234) begin
      failures++;
      $display("FAIL load_over_branch: pc=%h required pc=1234", pc_out);
    end
    br_offset = 16'h0000;
    step();
    checks++;
    if (pc_out !== 16'h1234 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL branch_zero: pc=%h wrap=%b required pc=1234 wrap=0", pc_out, wrap);
    end
    br_offset = 16'h0010; pc_ready = 1'b1;
    step();
    branch = 1'b0; pc_ready = 1'b0;
    checks++;
    if (pc_out !== 16'h1244 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL branch_over_acc: pc=%h wrap=%b required pc=1244 wrap=0", pc_out, wrap);
    end
  endtask

  task automatic test_halt();
    pc_ready = 1'b0;
    do_load(16'h0020);
    halt_req = 1'b1; pc_ready = 1'b1;
    step();
    halt_req = 1'b0;
    checks++;
    if (pc_out !== 16'h0021 || state !== 2'b10 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_acc: pc=%h state=%b valid=%b required pc=0021 state=10 valid=0",
               pc_out, state, pc_valid);
    end
    step();
    checks++;
    if (pc_out !== 16'h0021 || state !== 2'b10) begin
      failures++;
      $display("FAIL halt_hold: pc=%h state=%b required pc=0021 state=10", pc_out, state);
    end
    start = 1'b1; halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    checks++;
    if (state !== 2'b10) begin
      failures++;
      $display("FAIL halt_prio: state=%b required state=10", state);
    end
    step();
    start = 1'b0; pc_ready = 1'b0;
    checks++;
    if (pc_out !== 16'h0021 || state !== 2'b01 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart: pc=%h state=%b valid=%b required pc=0021 state=01 valid=1",
               pc_out, state, pc_valid);
    end
  endtask

  task automatic test_back_to_back();
    halt_req = 1'b1; load = 1'b1; load_addr = 16'h5555;
    step();
    halt_req = 1'b0; load = 1'b0;
    checks++;
    if (pc_out !== 16'h5555 || state !== 2'b10 || pc_valid !== 1'b0) begin
      failures++;
      $display("FAIL load_halt: pc=%h state=%b valid=%b required pc=5555 state=10 valid=0",
               pc_out, state, pc_valid);
    end
    branch = 1'b1; br_offset = 16'h0002;
    step();
    branch = 1'b0;
    checks++;
    if (pc_out !== 16'h5557 || state !== 2'b10) begin
      failures++;
      $display("FAIL branch_in_halt: pc=%h state=%b required pc=5557 state=10", pc_out, state);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (state !== 2'b01 || pc_valid !== 1'b1) begin
      failures++;
      $display("FAIL resume: state=%b valid=%b required state=01 valid=1", state, pc_valid);
    end
  endtask

  task automatic test_async_reset();
    pc_ready = 1'b0;
    do_load(16'h0ABC);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_out, pc_valid, wrap, state} !== {16'h0000, 1'b0, 1'b0, 2'b00}) begin
      failures++;
      $display("FAIL async_reset: pc=%h valid=%b wrap=%b state=%b required pc=0000 valid=0 wrap=0 state=00",
               pc_out, pc_valid, wrap, state);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (state !== 2'b00 || pc_out !== 16'h0000) begin
      failures++;
      $display("FAIL post_reset: state=%b pc=%h required state=00 pc=0000", state, pc_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_wrap();
    test_branch();
    test_halt();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
